// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin whole-frame arbiter onto one tx FIFO write port.
// Optional per-source frame/truncation counters under `TX_ARB_STATS_EN.
module tx_arbiter #(
   parameter int N          = 4,
   parameter int MAX_LEN    = 1518,
   parameter int GAP_CYCLES = 12
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   input  logic [N-1:0]         src_empty,
   input  logic [9*N-1:0]       src_dout,
   output logic [N-1:0]         src_rd_en,
   input  logic                 tx_full,
   output logic                 tx_wr_en,
   output logic [8:0]           tx_wr_data,
   output logic [N-1:0]         grant,
   output logic                 busy
`ifdef TX_ARB_STATS_EN
   ,
   input  logic [$clog2(N)-1:0] stat_sel,
   output logic [15:0]          stat_frames,
   output logic [15:0]          stat_trunc
`endif
);

   localparam int PW = $clog2(N);
   localparam int GW = $clog2(GAP_CYCLES) + 1;
   localparam logic [12:0]   LEN_MAX  = 13'(MAX_LEN);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, XFER, DROP, GAP} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] rr_ptr_q, rr_ptr_d;
   logic [12:0]   len_cnt_q, len_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          busy_q, busy_d;

   logic [8:0]    head_w [N];
   logic [N-1:0]  req, junk;
   logic [8:0]    head;
   logic [PW-1:0] cand, sel;
   logic          found;
   logic [N-1:0]  rd_en_c;
   logic          wr_en_c;
   logic [8:0]    wr_data_c;

   for (genvar i = 0; i < N; i++) begin : g_src
      assign head_w[i] = src_dout[9*i +: 9];
      assign req[i]    = !src_empty[i] && src_dout[9*i+8];
      assign junk[i]   = !src_empty[i] && !src_dout[9*i+8];
   end

   assign head = head_w[owner_q];

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      rr_ptr_d  = rr_ptr_q;
      len_cnt_d = len_cnt_q;
      gap_cnt_d = gap_cnt_q;
      rd_en_c   = '0;
      wr_en_c   = 1'b0;
      wr_data_c = 9'h000;
      found     = 1'b0;
      cand      = '0;
      sel       = '0;
      unique case (state_q)
         IDLE: begin
            // first requester at or after rr_ptr, wrapping
            for (int k = 0; k < N; k++) begin
               cand = PW'((int'(rr_ptr_q) + k) % N);
               if (!found && req[cand]) begin
                  found = 1'b1;
                  sel   = cand;
               end
            end
            if (found) begin
               state_d      = XFER;
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               owner_d      = sel;
               rr_ptr_d     = (sel == PW'(N-1)) ? '0 : sel + 1'b1;
               len_cnt_d    = '0;
            end else begin
               rd_en_c = junk & (~junk + 1'b1);
            end
         end
         XFER: begin
            if (len_cnt_q == LEN_MAX) begin
               if (!tx_full) begin
                  wr_en_c = 1'b1;
                  state_d = DROP;
               end
            end else if (!src_empty[owner_q] && !tx_full) begin
               rd_en_c[owner_q] = 1'b1;
               wr_en_c          = 1'b1;
               wr_data_c        = head;
               if (head[8]) begin
                  len_cnt_d = len_cnt_q + 13'd1;
               end else begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
               end
            end
         end
         DROP: begin
            if (!src_empty[owner_q]) begin
               rd_en_c[owner_q] = 1'b1;
               if (!head[8]) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q + 1'b1;
            if (gap_cnt_q == GAP_LAST) begin
               state_d = IDLE;
               grant_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         len_cnt_q <= '0;
         gap_cnt_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         rr_ptr_q  <= rr_ptr_d;
         len_cnt_q <= len_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         busy_q    <= busy_d;
      end
   end

   // strobes are forced low while reset is held, even mid-frame
   assign src_rd_en  = sys_rst ? '0 : rd_en_c;
   assign tx_wr_en   = sys_rst ? 1'b0 : wr_en_c;
   assign tx_wr_data = sys_rst ? 9'h000 : wr_data_c;
   assign grant      = grant_q;
   assign busy       = busy_q;

`ifdef TX_ARB_STATS_EN
   logic [N-1:0][15:0] frames_q, frames_d;
   logic [N-1:0][15:0] trunc_q, trunc_d;
   logic               term, cut;

   always_comb begin
      term = rd_en_c[owner_q] && !head[8]
             && (state_q == XFER || state_q == DROP);
      cut  = (state_q == XFER) && wr_en_c && (len_cnt_q == LEN_MAX);
      frames_d = frames_q;
      trunc_d  = trunc_q;
      if (term) frames_d[owner_q] = frames_q[owner_q] + 16'd1;
      if (cut)  trunc_d[owner_q]  = trunc_q[owner_q] + 16'd1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         frames_q <= '0;
         trunc_q  <= '0;
      end else begin
         frames_q <= frames_d;
         trunc_q  <= trunc_d;
      end
   end

   assign stat_frames = frames_q[stat_sel];
   assign stat_trunc  = trunc_q[stat_sel];
`endif

endmodule
